unigate_io_ctrl: RTL and testbench

Parametrised Wishbone-controlled GPIO bank for the user area. It drives `io_out`/`io_oeb` from software-writable registers and synchronises `io_in` into readable registers. It also latches per-pin edge events into write-1-to-clear status bits that raise `irq`. It sits between the management SoC Wishbone slave port and the IO pads, alongside the `unigate` core.

---
 rtl/unigate_io_ctrl.sv | 139 +++++++++++++
 tb/tb_unigate_io_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/unigate_io_ctrl.sv
// unigate_io_ctrl: Wishbone GPIO bank with pad output/enable registers and synchronised inputs.
// Define UNIGATE_IO_IRQ_EN to build the per-pin edge detect, IRQ_EN/EDGE/IRQ_STAT and irq lines.
module unigate_io_ctrl #(
  parameter int unsigned NUM_IO      = 38,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] ADR_BASE    = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oeb,
  output logic [2:0]        irq
);

  localparam logic [63:0] PIN_MASK = (NUM_IO >= 64) ? {64{1'b1}} : ((64'd1 << NUM_IO) - 64'd1);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t              r_state, w_state_nxt;
  logic [63:0]         r_out, r_oeb;
  logic [31:0]         r_dat;
  logic [NUM_IO-1:0]   r_sync [SYNC_STAGES];

  logic                w_sel, w_take, w_wr, w_hi, w_unused;
  logic [4:0]          w_idx;
  logic [31:0]         w_bm32, w_rd32;
  logic [63:0]         w_bm64, w_wd64, w_rd64, w_in64;
  logic [NUM_IO-1:0]   w_in;

  function automatic logic [63:0] f_merge(input logic [63:0] old, input logic [63:0] bm,
                                          input logic [63:0] wd);
    return ((old & ~bm) | (wd & bm)) & PIN_MASK;
  endfunction

  assign w_sel    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == ADR_BASE[31:8]);
  assign w_take   = (r_state == S_IDLE) & w_sel;
  assign w_wr     = w_take & wbs_we_i;
  assign w_idx    = wbs_adr_i[7:3];
  assign w_hi     = wbs_adr_i[2];
  assign w_unused = ^wbs_adr_i[1:0];
  assign w_bm32   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign w_bm64   = w_hi ? {w_bm32, 32'h0} : {32'h0, w_bm32};
  assign w_wd64   = {wbs_dat_i, wbs_dat_i};
  assign w_in     = r_sync[SYNC_STAGES-1];
  assign w_in64   = 64'(w_in);

  assign wbs_ack_o = (r_state == S_ACK);
  assign wbs_dat_o = r_dat;
  assign io_out    = r_out[NUM_IO-1:0];
  assign io_oeb    = r_oeb[NUM_IO-1:0];

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) r_state <= S_IDLE;
    else             r_state <= w_state_nxt;
  end

  // A strobe still high during ACK is not re-served: ACK always returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_sel) w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef UNIGATE_IO_IRQ_EN
  logic [63:0]       r_en, r_edge, r_stat, w_clr64;
  logic [NUM_IO-1:0] r_hist, w_evt, w_edge;
  logic [2:0]        r_irq;

  assign w_edge  = r_edge[NUM_IO-1:0];
  assign w_evt   = (w_in & ~r_hist & ~w_edge) | (~w_in & r_hist & w_edge);
  assign w_clr64 = (w_wr && w_idx == 5'd5) ? (w_wd64 & w_bm64) : 64'h0;
  assign irq     = r_irq;

  // A new event on the same edge as a W1C clear keeps the bit set.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_en   <= '0;
      r_edge <= '0;
      r_stat <= '0;
      r_hist <= '0;
      r_irq  <= '0;
    end else begin
      r_hist <= w_in;
      r_stat <= ((r_stat & ~w_clr64) | 64'(w_evt)) & PIN_MASK;
      if (w_wr && w_idx == 5'd3) r_en   <= f_merge(r_en, w_bm64, w_wd64);
      if (w_wr && w_idx == 5'd4) r_edge <= f_merge(r_edge, w_bm64, w_wd64);
      r_irq[0] <= |(r_stat[31:0] & r_en[31:0]);
      r_irq[1] <= |(r_stat[63:32] & r_en[63:32]);
      r_irq[2] <= |(r_stat & r_en);
    end
  end
`else
  assign irq = 3'b000;
`endif

  always_comb begin
    w_rd64 = '0;
    case (w_idx)
      5'd0: w_rd64 = r_out;
      5'd1: w_rd64 = r_oeb;
      5'd2: w_rd64 = w_in64;
`ifdef UNIGATE_IO_IRQ_EN
      5'd3: w_rd64 = r_en;
      5'd4: w_rd64 = r_edge;
      5'd5: w_rd64 = r_stat;
`endif
      default: w_rd64 = '0;
    endcase
    w_rd32 = w_hi ? w_rd64[63:32] : w_rd64[31:0];
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_out <= '0;
      r_oeb <= PIN_MASK;
      r_dat <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_dat <= w_take ? w_rd32 : 32'h0;
      if (w_wr && w_idx == 5'd0) r_out <= f_merge(r_out, w_bm64, w_wd64);
      if (w_wr && w_idx == 5'd1) r_oeb <= f_merge(r_oeb, w_bm64, w_wd64);
      r_sync[0] <= io_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

endmodule

// File: tb/tb_unigate_io_ctrl.sv
// Bench for unigate_io_ctrl: directed bus transfers with a read-data scoreboard and pad checks.
module tb_unigate_io_ctrl;
  localparam int NIO = 38;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]      sel = 4'h0;
  logic [31:0]     adr = 32'h0, wdat = 32'h0;
  logic            ack;
  logic [31:0]     rdat;
  logic [NIO-1:0]  io_in = '0;
  logic [NIO-1:0]  io_out, io_oeb;
  logic [2:0]      irq;

  typedef struct {
    bit          chk;
    logic [31:0] dat;
    string       nm;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;

  unigate_io_ctrl #(.NUM_IO(NIO), .SYNC_STAGES(2), .ADR_BASE(32'h3000_0000)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One Wishbone transfer; read data is checked by the monitor through the scoreboard.
  task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input bit exp_ack, input bit chk, input logic [31:0] exp, input string nm);
    int n;
    exp_t e;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    if (exp_ack) begin
      e.chk = chk; e.dat = exp; e.nm = nm;
      sb.push_back(e);
    end
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack && n < 8);
    if (exp_ack) check(ack && n == 1, {"ack_latency_", nm}, 64'(n), 64'd1);
    else         check(!ack, {"no_ack_", nm}, 64'(ack), 64'd0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check(!ack, {"ack_width_", nm}, 64'(ack), 64'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input string nm);
    xfer(1'b1, a, d, s, 1'b1, 1'b0, 32'h0, nm);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    xfer(1'b0, a, 32'h0, 4'hF, 1'b1, 1'b1, exp, nm);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (ack) begin
        if (sb.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_ack: got ack=1 expected no transfer (adr %h)", adr);
        end else begin
          e = sb.pop_front();
          if (e.chk) check(rdat == e.dat, {"rdata_", e.nm}, 64'(rdat), 64'(e.dat));
        end
      end else begin
        check(rdat == 32'h0, "rdata_idle_zero", 64'(rdat), 64'd0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    exp_t e;
    repeat (3) @(posedge clk);
    #1;
    check(io_out == '0, "rst_io_out", 64'(io_out), 64'd0);
    check(io_oeb == {NIO{1'b1}}, "rst_io_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    check(irq == 3'b000, "rst_irq", 64'(irq), 64'd0);
    check(!ack, "rst_ack", 64'(ack), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    wr(32'h3000_0008, 32'h0000_0000, 4'hF, "oeb_lo_clr");
    check(io_oeb == 38'h3F_0000_0000, "oeb_after_write", 64'(io_oeb), 64'h3F_0000_0000);

    // Reset asserted in the middle of an ACK cycle.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0000; wdat = 32'h0000_1234; sel = 4'hF;
    e.chk = 1'b0; e.dat = 32'h0; e.nm = "midrst";
    sb.push_back(e);
    @(posedge clk); #1;
    check(ack == 1'b1, "midrst_ack_before", 64'(ack), 64'd1);
    check(io_out == 38'h1234, "midrst_out_before", 64'(io_out), 64'h1234);
    #2 rst_n = 1'b0;
    #1;
    check(!ack, "midrst_ack_drop", 64'(ack), 64'd0);
    check(io_out == '0, "midrst_io_out", 64'(io_out), 64'd0);
    check(io_oeb == {NIO{1'b1}}, "midrst_io_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    check(irq == 3'b000, "midrst_irq", 64'(irq), 64'd0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    rd(32'h3000_0008, 32'hFFFF_FFFF, "oeb_lo_rst");
    rd(32'h3000_000C, 32'h0000_003F, "oeb_hi_rst");

    wr(32'h3000_0000, 32'hA5A5_A5A5, 4'b0011, "out_lo_bytes");
    check(io_out == 38'h0000_A5A5, "out_lo_bytes_pads", 64'(io_out), 64'h0000_A5A5);
    rd(32'h3000_0000, 32'h0000_A5A5, "out_lo");

    wr(32'h3000_0004, 32'hFFFF_FFFF, 4'hF, "out_hi_all");
    check(io_out == 38'h3F_0000_A5A5, "out_hi_pads", 64'(io_out), 64'h3F_0000_A5A5);
    rd(32'h3000_0004, 32'h0000_003F, "out_hi");

    wr(32'h3000_0008, 32'h0000_0000, 4'b1000, "oeb_lo_byte3");
    check(io_oeb == 38'h3F_00FF_FFFF, "oeb_byte3_pads", 64'(io_oeb), 64'h3F_00FF_FFFF);
    rd(32'h3000_0008, 32'h00FF_FFFF, "oeb_lo");

    wr(32'h3000_0040, 32'hDEAD_BEEF, 4'hF, "unmapped_wr");
    rd(32'h3000_0040, 32'h0000_0000, "unmapped_rd");
    rd(32'h3000_003C, 32'h0000_0000, "unmapped_3c");
    rd(32'h3000_0000, 32'h0000_A5A5, "out_lo_keep");
    check(io_oeb == 38'h3F_00FF_FFFF, "oeb_keep", 64'(io_oeb), 64'h3F_00FF_FFFF);

    xfer(1'b1, 32'h3000_0100, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, "outside_hi");
    xfer(1'b1, 32'h2000_0000, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, "outside_lo");
    check(io_out == 38'h3F_0000_A5A5, "outside_no_effect", 64'(io_out), 64'h3F_0000_A5A5);

    wr(32'h3000_0010, 32'hFFFF_FFFF, 4'hF, "in_ro_wr");
    rd(32'h3000_0010, 32'h0000_0000, "in_ro");

    // Synchroniser depth: first read captures before the change reaches IN.
    @(negedge clk) io_in = 38'h15_1234_5600;
    rd(32'h3000_0010, 32'h0000_0000, "in_before_sync");
    rd(32'h3000_0010, 32'h1234_5600, "in_lo");
    rd(32'h3000_0014, 32'h0000_0015, "in_hi");
    @(negedge clk) io_in = '0;
    repeat (4) @(negedge clk);

`ifdef UNIGATE_IO_IRQ_EN
    wr(32'h3000_0028, 32'hFFFF_FFFF, 4'hF, "stat_lo_clr_all");
    wr(32'h3000_002C, 32'hFFFF_FFFF, 4'hF, "stat_hi_clr_all");
    rd(32'h3000_0028, 32'h0000_0000, "stat_lo_clear");
    wr(32'h3000_0018, 32'h0000_0008, 4'hF, "en_bit3");
    wr(32'h3000_0020, 32'h0000_0000, 4'hF, "edge_rise");
    @(negedge clk) io_in[3] = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 3) check(irq == 3'b000, "irq_not_yet", 64'(irq), 64'd0);
      if (c == 4) check(irq == 3'b101, "irq_rise", 64'(irq), 64'h5);
    end
    rd(32'h3000_0028, 32'h0000_0008, "stat_bit3");
    rd(32'h3000_002C, 32'h0000_0000, "stat_hi_zero");
    wr(32'h3000_0028, 32'h0000_0008, 4'hF, "w1c_bit3");
    check(irq == 3'b000, "irq_after_w1c", 64'(irq), 64'd0);
    rd(32'h3000_0028, 32'h0000_0000, "stat_after_w1c");

    wr(32'h3000_0020, 32'h0000_0020, 4'hF, "edge_fall5");
    @(negedge clk) io_in[5] = 1'b1;
    repeat (6) @(posedge clk);
    rd(32'h3000_0028, 32'h0000_0000, "rise_ignored5");
    @(negedge clk) io_in[5] = 1'b0;
    @(negedge clk);
    wr(32'h3000_0028, 32'h0000_0020, 4'hF, "w1c_collide5");
    rd(32'h3000_0028, 32'h0000_0020, "set_wins5");
    check(irq == 3'b000, "irq_masked5", 64'(irq), 64'd0);
    wr(32'h3000_0018, 32'h0000_0028, 4'hF, "en_bit5");
    check(irq == 3'b101, "irq_en5", 64'(irq), 64'h5);
    wr(32'h3000_0018, 32'h0000_0000, 4'hF, "en_off");
    check(irq == 3'b000, "irq_en_off", 64'(irq), 64'd0);
    rd(32'h3000_0028, 32'h0000_0020, "stat_kept");
`else
    wr(32'h3000_0018, 32'hFFFF_FFFF, 4'hF, "en_absent_wr");
    rd(32'h3000_0018, 32'h0000_0000, "en_absent");
    rd(32'h3000_0020, 32'h0000_0000, "edge_absent");
    @(negedge clk) io_in[3] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check(irq == 3'b000, "irq_tied", 64'(irq), 64'd0);
    rd(32'h3000_0028, 32'h0000_0000, "stat_absent");
    rd(32'h3000_0010, 32'h0000_0008, "in_bit3");
`endif

    repeat (3) @(posedge clk);
    check(sb.size() == 0, "scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
